// File: rtl/intf_change_reader_if.sv
// Shared data interface between the modules that write p.data and the change reader.
interface intf #(
  parameter int unsigned WIDTH = 3
) ();
  logic [WIDTH-1:0] data;

  modport master (output data);
  modport slave  (input  data);
endinterface

// File: rtl/intf_change_reader.sv
// Watches the data interface for value changes and queues each new value in a small FIFO
// that is drained over a valid/ready stream; also counts changes and flags dropped ones.
module intf_change_reader #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned DEPTH     = 4,
  parameter bit          BIT0_ONLY = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  intf.slave               p,
  input  logic             enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       change_count,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] v;
  logic             empty, full, change, pop, push;

  always_comb begin
    v = '0;
    if (BIT0_ONLY) v[0] = p.data[0];
    else           v    = p.data;
  end

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign change = (state_q == RUN) && enable && (v != prev_q);
  assign pop    = out_valid && out_ready;
  assign push   = change && (!full || pop);

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (enable) begin
        prev_d  = v;
        state_d = RUN;
      end
      default: if (!enable) begin
        state_d = IDLE;
      end else begin
        prev_d = v;
      end
    endcase
    if (change && count_q != 8'hFF) count_d = count_q + 8'd1;
    if (change && !push)            ovf_d   = 1'b1;
    if (push)                       wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)                        rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q[AW-1:0]] <= v;
  end

  assign out_valid    = !empty;
  assign out_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign change_count = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_intf_change_reader.sv
// Directed vector bench for intf_change_reader: full-width instance plus a bit-0-only instance.
module tb_intf_change_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intf #(.WIDTH(3)) bus  ();
  intf #(.WIDTH(3)) bus0 ();

  logic       en, rdy, vld;
  logic [2:0] odat;
  logic [7:0] cnt;
  logic       ovf;

  logic       en0, rdy0, vld0;
  logic [2:0] odat0;
  logic [7:0] cnt0;
  logic       ovf0;

  intf_change_reader #(.WIDTH(3), .DEPTH(4), .BIT0_ONLY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .p(bus), .enable(en),
    .out_valid(vld), .out_ready(rdy), .out_data(odat),
    .change_count(cnt), .overflow(ovf)
  );

  intf_change_reader #(.WIDTH(3), .DEPTH(4), .BIT0_ONLY(1'b1)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .p(bus0), .enable(en0),
    .out_valid(vld0), .out_ready(rdy0), .out_data(odat0),
    .change_count(cnt0), .overflow(ovf0)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [2:0] d;
    logic       ev;
    logic [2:0] ed;
    logic [7:0] ec;
    logic       eo;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(string name, logic r, logic e, logic rd, logic [2:0] d,
                              logic ev, logic [2:0] ed, logic [7:0] ec, logic eo);
    vec_t t;
    t.name = name; t.rst_n = r; t.en = e; t.rdy = rd; t.d = d;
    t.ev = ev; t.ed = ed; t.ec = ec; t.eo = eo;
    vecs.push_back(t);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rdy = 1'b0; bus.data = '0;
    en0 = 1'b0; rdy0 = 1'b0; bus0.data = '0;

    //   name        rst en rdy d     ev ed    ec   eo
    add("rst_a",     0, 1, 0, 3'd0, 0, 3'd0, 8'd0, 0);
    add("rst_b",     0, 1, 0, 3'd7, 0, 3'd0, 8'd0, 0);
    add("bas_prime", 1, 1, 1, 3'd0, 0, 3'd0, 8'd0, 0);
    add("bas_hold",  1, 1, 1, 3'd0, 0, 3'd0, 8'd0, 0);
    add("bas_5",     1, 1, 1, 3'd5, 1, 3'd5, 8'd1, 0);
    add("bas_2",     1, 1, 1, 3'd2, 1, 3'd2, 8'd2, 0);
    add("bas_drain", 1, 1, 1, 3'd2, 0, 3'd0, 8'd2, 0);
    add("ovf_rst",   0, 0, 0, 3'd0, 0, 3'd0, 8'd0, 0);
    add("ovf_prime", 1, 1, 0, 3'd0, 0, 3'd0, 8'd0, 0);
    add("ovf_1",     1, 1, 0, 3'd1, 1, 3'd1, 8'd1, 0);
    add("ovf_2",     1, 1, 0, 3'd2, 1, 3'd1, 8'd2, 0);
    add("ovf_3",     1, 1, 0, 3'd3, 1, 3'd1, 8'd3, 0);
    add("ovf_4",     1, 1, 0, 3'd4, 1, 3'd1, 8'd4, 0);
    add("ovf_5",     1, 1, 0, 3'd5, 1, 3'd1, 8'd5, 1);
    add("ovf_6",     1, 1, 0, 3'd6, 1, 3'd1, 8'd6, 1);
    add("ovf_pop2",  1, 1, 1, 3'd6, 1, 3'd2, 8'd6, 1);
    add("ovf_pop3",  1, 1, 1, 3'd6, 1, 3'd3, 8'd6, 1);
    add("ovf_pop4",  1, 1, 1, 3'd6, 1, 3'd4, 8'd6, 1);
    add("ovf_empty", 1, 1, 1, 3'd6, 0, 3'd0, 8'd6, 1);
    add("fp_rst",    0, 0, 0, 3'd0, 0, 3'd0, 8'd0, 0);
    add("fp_prime",  1, 1, 0, 3'd0, 0, 3'd0, 8'd0, 0);
    add("fp_1",      1, 1, 0, 3'd1, 1, 3'd1, 8'd1, 0);
    add("fp_2",      1, 1, 0, 3'd2, 1, 3'd1, 8'd2, 0);
    add("fp_3",      1, 1, 0, 3'd3, 1, 3'd1, 8'd3, 0);
    add("fp_4",      1, 1, 0, 3'd4, 1, 3'd1, 8'd4, 0);
    add("fp_7",      1, 1, 1, 3'd7, 1, 3'd2, 8'd5, 0);
    add("fp_pop3",   1, 1, 1, 3'd7, 1, 3'd3, 8'd5, 0);
    add("fp_pop4",   1, 1, 1, 3'd7, 1, 3'd4, 8'd5, 0);
    add("fp_pop7",   1, 1, 1, 3'd7, 1, 3'd7, 8'd5, 0);
    add("fp_empty",  1, 1, 1, 3'd7, 0, 3'd0, 8'd5, 0);
    add("rp_rst",    0, 0, 0, 3'd3, 0, 3'd0, 8'd0, 0);
    add("rp_prime",  1, 1, 0, 3'd3, 0, 3'd0, 8'd0, 0);
    add("rp_off_a",  1, 0, 0, 3'd3, 0, 3'd0, 8'd0, 0);
    add("rp_off_b",  1, 0, 0, 3'd6, 0, 3'd0, 8'd0, 0);
    add("rp_off_c",  1, 0, 0, 3'd6, 0, 3'd0, 8'd0, 0);
    add("rp_reen",   1, 1, 0, 3'd6, 0, 3'd0, 8'd0, 0);
    add("rp_1",      1, 1, 0, 3'd1, 1, 3'd1, 8'd1, 0);
    add("rp_midrst", 0, 1, 0, 3'd1, 0, 3'd0, 8'd0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; rdy = vecs[i].rdy; bus.data = vecs[i].d;
      step();
      check({vecs[i].name, ".valid"}, 32'(vld),  32'(vecs[i].ev));
      check({vecs[i].name, ".data"},  32'(odat), 32'(vecs[i].ed));
      check({vecs[i].name, ".count"}, 32'(cnt),  32'(vecs[i].ec));
      check({vecs[i].name, ".ovf"},   32'(ovf),  32'(vecs[i].eo));
    end

    // Change counter saturation: 300 toggles with a draining consumer.
    rst_n = 1'b1; en = 1'b1; rdy = 1'b1; bus.data = 3'd0;
    step();
    for (int i = 0; i < 300; i++) begin
      bus.data = (i % 2 == 0) ? 3'd1 : 3'd0;
      step();
      if (i == 253) check("sat_254", 32'(cnt), 32'd254);
    end
    check("sat_255",  32'(cnt), 32'd255);
    check("sat_ovf",  32'(ovf), 32'd0);
    check("sat_head", 32'(odat), 32'd0);

    // Bit-0-only view: upper-bit changes are invisible.
    check("b0_reset_valid", 32'(vld0), 32'd0);
    en0 = 1'b1; rdy0 = 1'b0; bus0.data = 3'b110;
    step();
    check("b0_prime_valid", 32'(vld0), 32'd0);
    bus0.data = 3'b111;
    step();
    check("b0_push_valid", 32'(vld0),  32'd1);
    check("b0_push_data",  32'(odat0), 32'd1);
    check("b0_push_count", 32'(cnt0),  32'd1);
    bus0.data = 3'b011;
    step();
    check("b0_hi_count", 32'(cnt0),  32'd1);
    check("b0_hi_data",  32'(odat0), 32'b001);
    rdy0 = 1'b1;
    step();
    check("b0_pop_valid", 32'(vld0), 32'd0);
    check("b0_ovf",       32'(ovf0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
